// File: rtl/conv_window_3x3.sv
// ============================================================================
// Module   : conv_window_3x3
// Brief    : Sliding 3x3 window generator built on two line buffers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_3x3 #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   in,
  output logic [9*DATA_WIDTH-1:0] out_win,
  output logic                    out_valid,
  output logic                    frame_done
);

  localparam int c_col_w = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int c_row_w = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_WIDTH - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_HEIGHT - 1);
  localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
  localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);

  logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb2 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_win [3][3];
  logic [c_col_w-1:0]    r_col;
  logic [c_row_w-1:0]    r_row;
  logic                  r_valid;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] w_lb1_out;
  logic [DATA_WIDTH-1:0] w_lb2_out;
  logic                  w_last_col;
  logic                  w_last_row;

  assign w_lb1_out  = r_lb1[IMG_WIDTH-1];
  assign w_lb2_out  = r_lb2[IMG_WIDTH-1];
  assign w_last_col = (r_col == c_col_last);
  assign w_last_row = (r_row == c_row_last);

  // Line buffers and window advance together, so every delay is in accepted pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        r_lb1[i] <= '0;
        r_lb2[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (en) begin
      r_lb1[0] <= in;
      r_lb2[0] <= w_lb1_out;
      for (int i = 1; i < IMG_WIDTH; i++) begin
        r_lb1[i] <= r_lb1[i-1];
        r_lb2[i] <= r_lb2[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_lb2_out;
      r_win[1][2] <= w_lb1_out;
      r_win[2][2] <= in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Columns 0/1 and rows 0/1 still hold stale data from the previous row/frame.
      r_valid <= en && (r_row >= c_row_two) && (r_col >= c_col_two);
      r_done  <= en && w_last_row && w_last_col;
      if (en) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  for (genvar gr = 0; gr < 3; gr++) begin : g_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      assign out_win[DATA_WIDTH*(3*gr+gc) +: DATA_WIDTH] = r_win[gr][gc];
    end
  end

  assign out_valid  = r_valid;
  assign frame_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_3x3.sv
// ============================================================================
// Module   : tb_conv_window_3x3
// Brief    : Self-checking bench for conv_window_3x3 (default and 5x4x8 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_3x3;

  localparam int W   = 28;
  localparam int H   = 28;
  localparam int DW  = 32;
  localparam int SW  = 5;
  localparam int SH  = 4;
  localparam int SDW = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            en;
  logic [DW-1:0]   din;
  logic [9*DW-1:0] out_win;
  logic            out_valid;
  logic            frame_done;

  logic             en_s;
  logic [SDW-1:0]   din_s;
  logic [9*SDW-1:0] win_s;
  logic             valid_s;
  logic             done_s;

  conv_window_3x3 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .in        (din),
    .out_win   (out_win),
    .out_valid (out_valid),
    .frame_done(frame_done)
  );

  conv_window_3x3 #(.IMG_WIDTH(SW), .IMG_HEIGHT(SH), .DATA_WIDTH(SDW)) dut_s (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en_s),
    .in        (din_s),
    .out_win   (win_s),
    .out_valid (valid_s),
    .frame_done(done_s)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [9*DW-1:0] q[$];
  int              m_row;
  int              m_col;
  int              n_valid;
  int              n_fd;
  bit              got_first;
  logic [9*DW-1:0] first_win;
  logic [9*DW-1:0] last_win;

  typedef struct {
    logic           e;
    logic [SDW-1:0] pix;
    logic           v;
    logic           fd;
    logic [9*SDW-1:0] win;
  } vec_t;

  vec_t tbl[24];

  task automatic check_vec(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (row %0d col %0d)", name, act, exp, m_row, m_col);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [9*DW-1:0] w9(input int dw, input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7, input int a8);
    int a[9];
    logic [9*DW-1:0] ret;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3; a[4] = a4;
    a[5] = a5; a[6] = a6; a[7] = a7; a[8] = a8;
    ret = '0;
    for (int k = 0; k < 9; k++) ret = ret | ((288'(a[k]) & ((288'(1) << dw) - 288'(1))) << (dw*k));
    return ret;
  endfunction

  // Expected window for bottom-right pixel (row,col) of a ramp frame with offset base.
  function automatic logic [9*DW-1:0] model_win(input int base, input int row, input int col, input int w, input int dw);
    logic [9*DW-1:0] ret;
    ret = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        ret = ret | (288'(base + (row-2+r)*w + (col-2+c)) << (dw*(3*r+c)));
    return ret;
  endfunction

  task automatic reset_stats();
    n_valid   = 0;
    n_fd      = 0;
    got_first = 0;
    first_win = '0;
    last_win  = '0;
  endtask

  // Called at a negedge; drives one cycle and checks the outputs 1ns after the posedge.
  task automatic step(input logic e, input int base);
    logic ev;
    logic efd;
    logic [9*DW-1:0] exp_w;
    ev  = 1'b0;
    efd = 1'b0;
    en  = e;
    din = e ? DW'(base + m_row*W + m_col) : DW'($urandom);
    if (e) begin
      if (m_row >= 2 && m_col >= 2) begin
        ev = 1'b1;
        q.push_back(model_win(base, m_row, m_col, W, DW));
      end
      efd = (m_row == H-1) && (m_col == W-1);
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
    @(posedge clk);
    #1;
    check_bit("out_valid", out_valid, ev);
    check_bit("frame_done", frame_done, efd);
    if (frame_done) n_fd++;
    if (out_valid) begin
      n_valid++;
      if (q.size() == 0) begin
        check_int("scoreboard_empty", 0, 1);
      end else begin
        exp_w = q.pop_front();
        check_vec("window", out_win, exp_w);
        if (!got_first) begin
          first_win = out_win;
          got_first = 1;
        end
        last_win = out_win;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int base, input bit gaps);
    int acc;
    int cyc;
    logic e;
    acc = 0;
    cyc = 0;
    while (acc < W*H && cyc < 20000) begin
      e = gaps ? logic'($urandom_range(0, 1)) : 1'b1;
      step(e, base);
      if (e) acc++;
      cyc++;
    end
    check_int("frame_accepted", acc, W*H);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    int c;
    int n_vs;
    bit first_s;
    logic [9*DW-1:0] first_s_win;

    reset_n = 1'b0;
    en      = 1'b0;
    din     = '0;
    en_s    = 1'b0;
    din_s   = '0;
    m_row   = 0;
    m_col   = 0;
    reset_stats();

    repeat (2) @(negedge clk);
    check_vec("reset_out_win", out_win, '0);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_frame_done", frame_done, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Continuous ramp frame
    reset_stats();
    run_frame(0, 0);
    check_int("ramp_valid_count", n_valid, 676);
    check_int("ramp_done_count", n_fd, 1);
    check_vec("ramp_first_win", first_win, w9(DW, 0, 1, 2, 28, 29, 30, 56, 57, 58));
    check_vec("ramp_last_win", last_win, w9(DW, 725, 726, 727, 753, 754, 755, 781, 782, 783));
    check_int("ramp_queue_empty", q.size(), 0);

    // Ramp frame with random enable gaps
    reset_stats();
    run_frame(0, 1);
    check_int("gap_valid_count", n_valid, 676);
    check_int("gap_done_count", n_fd, 1);
    check_vec("gap_first_win", first_win, w9(DW, 0, 1, 2, 28, 29, 30, 56, 57, 58));
    check_vec("gap_last_win", last_win, w9(DW, 725, 726, 727, 753, 754, 755, 781, 782, 783));
    check_int("gap_queue_empty", q.size(), 0);

    // Back-to-back frames, second offset by 1000
    reset_stats();
    run_frame(0, 0);
    reset_stats();
    run_frame(1000, 0);
    check_int("b2b_valid_count", n_valid, 676);
    check_vec("b2b_first_win", first_win, w9(DW, 1000, 1001, 1002, 1028, 1029, 1030, 1056, 1057, 1058));
    check_vec("b2b_last_win", last_win, w9(DW, 1725, 1726, 1727, 1753, 1754, 1755, 1781, 1782, 1783));
    check_int("b2b_queue_empty", q.size(), 0);

    // Asynchronous reset in the middle of row 10
    reset_stats();
    while (!(m_row == 10 && m_col == 5)) step(1'b1, 0);
    check_bit("pre_reset_valid", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_bit("async_reset_valid", out_valid, 1'b0);
    check_bit("async_reset_done", frame_done, 1'b0);
    check_vec("async_reset_win", out_win, '0);
    q.delete();
    m_row = 0;
    m_col = 0;
    en    = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    reset_stats();
    run_frame(0, 0);
    check_int("rst_valid_count", n_valid, 676);
    check_int("rst_done_count", n_fd, 1);
    check_vec("rst_first_win", first_win, w9(DW, 0, 1, 2, 28, 29, 30, 56, 57, 58));
    check_vec("rst_last_win", last_win, w9(DW, 725, 726, 727, 753, 754, 755, 781, 782, 783));
    en = 1'b0;

    // 5x4x8 build: table of vectors with an idle cycle every sixth entry
    r = 0;
    c = 0;
    for (int i = 0; i < 24; i++) begin
      tbl[i].e = (i % 6 != 5);
      if (tbl[i].e) begin
        tbl[i].pix = SDW'(r*SW + c);
        tbl[i].v   = (r >= 2) && (c >= 2);
        tbl[i].fd  = (r == SH-1) && (c == SW-1);
        tbl[i].win = (9*SDW)'(model_win(0, r, c, SW, SDW));
        if (c == SW-1) begin
          c = 0;
          r = (r == SH-1) ? 0 : r + 1;
        end else begin
          c = c + 1;
        end
      end else begin
        tbl[i].pix = 8'hAA;
        tbl[i].v   = 1'b0;
        tbl[i].fd  = 1'b0;
        tbl[i].win = '0;
      end
    end

    n_vs        = 0;
    first_s     = 0;
    first_s_win = '0;
    for (int i = 0; i < 24; i++) begin
      en_s  = tbl[i].e;
      din_s = tbl[i].pix;
      @(posedge clk);
      #1;
      check_bit("small_valid", valid_s, tbl[i].v);
      check_bit("small_done", done_s, tbl[i].fd);
      if (valid_s) begin
        n_vs++;
        if (!first_s) begin
          first_s_win = {216'b0, win_s};
          first_s     = 1;
        end
      end
      if (tbl[i].v) check_vec("small_window", {216'b0, win_s}, {216'b0, tbl[i].win});
      @(negedge clk);
    end
    en_s = 1'b0;
    check_int("small_valid_count", n_vs, 6);
    check_vec("small_first_win", first_s_win, w9(SDW, 0, 1, 2, 5, 6, 7, 10, 11, 12));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
